svc_rv_bpred_bht: RTL and testbench
===================================

# svc_rv_bpred_bht

Branch history table controller for the pipelined RV core with BPRED enabled: owns a table of 2-bit saturating counters indexed by PC, serves a registered taken/not-taken prediction to fetch, and applies resolved-branch updates from execute. A built-in init sequencer walks the table after reset or a flush request, so the storage itself carries no reset and maps to distributed RAM/BRAM.

## Interface
- IDX_W, 6, table index width; 2**IDX_W entries
- XLEN, 32, PC width
- INIT_CNT, 2'b01, counter value written by the init sequencer (weakly not-taken)

Ports:
- clk  in  1  core clock; the block's only clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  restart the init sequencer (context switch / fence)
- init_busy  out  1  table initialization in progress
- pred_valid  in  1  lookup request from fetch
- pred_pc  in  XLEN  PC of the fetched instruction
- pred_taken  out  1  prediction for the previous cycle's lookup
- upd_valid  in  1  resolved conditional branch from execute
- upd_pc  in  XLEN  PC of the resolved branch
- upd_taken  in  1  actual branch outcome

## Operation
- Index = pc[IDX_W+1:2]; pc[1:0] ignored.
- FSM states: INIT, RUN.
- INIT:
  - One entry per cycle: table[init_idx] <= INIT_CNT, init_idx++.
  - After writing entry 2**IDX_W-1, go to RUN.
  - Lookups return 0; updates are dropped.
- RUN:
  - Lookup: pred_taken <= pred_valid & table[pidx][1].
  - Update: read-modify-write of table[uidx] in one cycle.
    - Taken: +1, saturating at 3.
    - Not taken: -1, saturating at 0.
- Same-cycle lookup and update to the same index: write-first. pred_taken reflects the post-update counter MSB.
- flush in RUN: go to INIT, init_idx <= 0. Any same-cycle update is dropped and pred_taken <= 0.
- flush in INIT: restart with init_idx <= 0.
- Async reset: state = INIT, init_idx = 0, pred_taken = 0, init_busy = 1. Table contents are not reset.

## Timing
- Lookup latency: 1 cycle. pred_pc presented in cycle N gives pred_taken valid in N+1, aligned with the registered BRAM imem fetch.
- When pred_valid = 0, pred_taken = 0 the next cycle.
- Update is visible to lookups issued in the same cycle (bypass) and to all later cycles.
- Init duration: exactly 2**IDX_W cycles after rst_n deasserts or after the flush cycle.
  - init_busy is 1 on every cycle of INIT.
  - It drops in the cycle after the last write.
- A flush arriving while init_busy is high extends init to 2**IDX_W cycles from the flush.
- Reset asserted mid-init or mid-update: an update in progress is lost; init restarts from entry 0.
- No backpressure. Inputs are sampled every cycle; no handshake beyond the valid strobes.

## Structure
- Shared package svc_rv_bpred_pkg:
  - state enum (BHT_INIT, BHT_RUN)
  - counter constants CNT_SNT=0, CNT_WNT=1, CNT_WT=2, CNT_ST=3
  - function for the saturating next-count
- One sub-module, svc_rv_bpred_bht_mem: 2**IDX_W x 2-bit storage.
  - One combinational read port for update RMW; one read port for lookup.
  - One write port; no reset.
- Controller (FSM, init counter, write mux, bypass) lives in svc_rv_bpred_bht.
- Estimated 150–250 lines RTL total.

## Test plan
- Reset init, IDX_W=4:
  - Release rst_n → init_busy high for exactly 16 cycles, then low.
  - Lookups at every index → pred_taken=0.
- Saturation, pc=0x40 (idx 0):
  - 3 taken updates → lookups read 1 after the 1st update (counter WNT→WT).
  - 5 further taken updates → counter stays 3.
  - 2 not-taken updates → counter 1, pred_taken=0.
- Bypass:
  - Counter at 1; in one cycle, upd_valid=1, upd_taken=1 and pred_valid=1 at the same pc.
  - → pred_taken=1 the next cycle.
- Aliasing, IDX_W=4:
  - Train pc=0x10 to 3 → lookup of pc=0x50 (same index) predicts 1.
  - Lookup of pc=0x14 → 0.
- Flush:
  - Train several entries, then pulse flush together with an update.
  - → init_busy high 16 cycles, the update is dropped, all entries predict 0 afterward.
- Reset mid-init:
  - Assert rst_n low at init cycle 7, release.
  - → full 16-cycle init; no update during init changes any counter.

Source files
------------

// File: rtl/svc_rv_bpred_pkg.sv
// Shared types and helpers for the RV branch predictor blocks.
// Holds the BHT controller states and 2-bit saturating counter arithmetic.
package svc_rv_bpred_pkg;

  typedef enum logic {
    BHT_INIT = 1'b0,
    BHT_RUN  = 1'b1
  } bht_state_t;

  localparam logic [1:0] CNT_SNT = 2'd0;
  localparam logic [1:0] CNT_WNT = 2'd1;
  localparam logic [1:0] CNT_WT  = 2'd2;
  localparam logic [1:0] CNT_ST  = 2'd3;

  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
    end else begin
      res = (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/svc_rv_bpred_bht_mem.sv
// 2**IDX_W x 2-bit counter storage: one write port, two asynchronous read ports.
// Carries no reset so it maps onto distributed RAM.
module svc_rv_bpred_bht_mem #(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [1:0]       wdata,
  input  logic [IDX_W-1:0] upd_raddr,
  output logic [1:0]       upd_rdata,
  input  logic [IDX_W-1:0] pred_raddr,
  output logic [1:0]       pred_rdata
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign upd_rdata  = mem[upd_raddr];
  assign pred_rdata = mem[pred_raddr];

endmodule

// File: rtl/svc_rv_bpred_bht.sv
// Branch history table controller: init sequencer, registered lookup for fetch,
// and single-cycle read-modify-write updates from execute with write-first bypass.
module svc_rv_bpred_bht
  import svc_rv_bpred_pkg::*;
#(
  parameter int         IDX_W    = 6,
  parameter int         XLEN     = 32,
  parameter logic [1:0] INIT_CNT = 2'b01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  output logic            init_busy,
  input  logic            pred_valid,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_taken,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken
);

  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  bht_state_t       state_reg, state_next;
  logic [IDX_W-1:0] init_idx_reg, init_idx_next;
  logic             pred_taken_reg, pred_taken_next;

  logic [IDX_W-1:0] pidx, uidx;
  logic [1:0]       upd_rdata, pred_rdata, upd_cnt;
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [1:0]       mem_wdata;

  assign pidx    = pred_pc[IDX_W+1:2];
  assign uidx    = upd_pc[IDX_W+1:2];
  assign upd_cnt = cnt_next(upd_rdata, upd_taken);

  // Only the index bits of the PCs are used.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0],
                            upd_pc[XLEN-1:IDX_W+2], upd_pc[1:0]};

  svc_rv_bpred_bht_mem #(
    .IDX_W(IDX_W)
  ) u_mem (
    .clk       (clk),
    .we        (mem_we),
    .waddr     (mem_waddr),
    .wdata     (mem_wdata),
    .upd_raddr (uidx),
    .upd_rdata (upd_rdata),
    .pred_raddr(pidx),
    .pred_rdata(pred_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= BHT_INIT;
      init_idx_reg   <= '0;
      pred_taken_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      init_idx_reg   <= init_idx_next;
      pred_taken_reg <= pred_taken_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    init_idx_next   = init_idx_reg;
    pred_taken_next = 1'b0;
    mem_we          = 1'b0;
    mem_waddr       = init_idx_reg;
    mem_wdata       = INIT_CNT;
    case (state_reg)
      BHT_INIT: begin
        if (flush) begin
          init_idx_next = '0;
        end else begin
          mem_we        = 1'b1;
          init_idx_next = init_idx_reg + 1'b1;
          if (init_idx_reg == IDX_LAST) begin
            state_next = BHT_RUN;
          end
        end
      end
      BHT_RUN: begin
        if (flush) begin
          state_next    = BHT_INIT;
          init_idx_next = '0;
        end else begin
          if (upd_valid) begin
            mem_we    = 1'b1;
            mem_waddr = uidx;
            mem_wdata = upd_cnt;
          end
          // Write-first: a same-index update is seen by the lookup this cycle.
          if (upd_valid && (uidx == pidx)) begin
            pred_taken_next = pred_valid & upd_cnt[1];
          end else begin
            pred_taken_next = pred_valid & pred_rdata[1];
          end
        end
      end
      default: begin
        state_next    = BHT_INIT;
        init_idx_next = '0;
      end
    endcase
  end

  assign init_busy  = (state_reg == BHT_INIT);
  assign pred_taken = pred_taken_reg;

endmodule

// File: tb/tb_svc_rv_bpred_bht.sv
// Directed bench for svc_rv_bpred_bht with IDX_W=4: init timing, saturation,
// bypass, aliasing, flush and reset-during-init behaviour.
module tb_svc_rv_bpred_bht;

  localparam int IDX_W = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            init_busy;
  logic            pred_valid;
  logic [XLEN-1:0] pred_pc;
  logic            pred_taken;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  svc_rv_bpred_bht #(
    .IDX_W   (IDX_W),
    .XLEN    (XLEN),
    .INIT_CNT(2'b01)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .init_busy (init_busy),
    .pred_valid(pred_valid),
    .pred_pc   (pred_pc),
    .pred_taken(pred_taken),
    .upd_valid (upd_valid),
    .upd_pc    (upd_pc),
    .upd_taken (upd_taken)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("pass %s got=%0d", tag, got);
    end else begin
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Lookup issued for one cycle; result checked on the following cycle.
  task automatic lookup(input logic [31:0] pc, input logic v, input logic exp, input string tag);
    pred_valid = v;
    pred_pc    = pc;
    @(negedge clk);
    pred_valid = 1'b0;
    chk(tag, {31'd0, pred_taken}, {31'd0, exp});
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken);
    upd_valid = 1'b1;
    upd_pc    = pc;
    upd_taken = taken;
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  // Counts cycles with init_busy high (bounded) and records any prediction seen meanwhile.
  task automatic wait_init(input string tag);
    int   n    = 0;
    logic seen = 1'b0;
    while (init_busy && n < 100) begin
      @(negedge clk);
      n++;
      seen = seen | pred_taken;
    end
    chk({tag, "_len"}, n, 16);
    chk({tag, "_pred"}, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    pred_valid = 1'b0;
    pred_pc    = '0;
    upd_valid  = 1'b0;
    upd_pc     = '0;
    upd_taken  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, init_busy}, 32'd1);
    chk("rst_pred", {31'd0, pred_taken}, 32'd0);

    // Reset init with lookups held during init
    rst_n      = 1'b1;
    pred_valid = 1'b1;
    pred_pc    = 32'h10;
    wait_init("init");
    pred_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      lookup(i << 2, 1'b1, 1'b0, $sformatf("init_idx%0d", i));
    end

    // Saturation high on idx 0
    upd(32'h40, 1'b1);
    lookup(32'h40, 1'b1, 1'b1, "sat_first_t");
    upd(32'h40, 1'b1);
    upd(32'h40, 1'b1);
    for (int i = 0; i < 5; i++) upd(32'h40, 1'b1);
    lookup(32'h40, 1'b1, 1'b1, "sat_hi_hold");
    upd(32'h40, 1'b0);
    lookup(32'h40, 1'b1, 1'b1, "sat_hi_nt1");
    upd(32'h40, 1'b0);
    lookup(32'h40, 1'b1, 1'b0, "sat_hi_nt2");
    // Saturation low
    for (int i = 0; i < 3; i++) upd(32'h40, 1'b0);
    upd(32'h40, 1'b1);
    lookup(32'h40, 1'b1, 1'b0, "sat_lo_t1");
    upd(32'h40, 1'b1);
    lookup(32'h40, 1'b1, 1'b1, "sat_lo_t2");
    upd(32'h40, 1'b0);

    // Bypass: idx0 at 1, same-cycle taken update and lookup
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
    pred_valid = 1'b1; pred_pc = 32'h43;
    @(negedge clk);
    upd_valid = 1'b0; pred_valid = 1'b0;
    chk("bypass_t", {31'd0, pred_taken}, 32'd1);
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b0;
    pred_valid = 1'b1; pred_pc = 32'h40;
    @(negedge clk);
    upd_valid = 1'b0; pred_valid = 1'b0;
    chk("bypass_nt", {31'd0, pred_taken}, 32'd0);
    upd_valid = 1'b1; upd_pc = 32'h44; upd_taken = 1'b1;
    pred_valid = 1'b1; pred_pc = 32'h40;
    @(negedge clk);
    upd_valid = 1'b0; pred_valid = 1'b0;
    chk("bypass_other_idx", {31'd0, pred_taken}, 32'd0);
    lookup(32'h44, 1'b1, 1'b1, "other_idx_written");

    // Aliasing
    upd(32'h10, 1'b1);
    upd(32'h10, 1'b1);
    lookup(32'h50, 1'b1, 1'b1, "alias_same");
    lookup(32'h14, 1'b1, 1'b0, "alias_next");
    lookup(32'h10, 1'b0, 1'b0, "pred_valid_low");

    // Flush in RUN with a same-cycle update, then flush again mid-init
    upd(32'h1c, 1'b1);
    lookup(32'h1c, 1'b1, 1'b1, "train_idx7");
    flush = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h14; upd_taken = 1'b1;
    pred_valid = 1'b1; pred_pc = 32'h10;
    @(negedge clk);
    flush = 1'b0; upd_valid = 1'b0;
    chk("flush_pred", {31'd0, pred_taken}, 32'd0);
    chk("flush_busy", {31'd0, init_busy}, 32'd1);
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_init("flush_init");
    pred_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      lookup(i << 2, 1'b1, 1'b0, $sformatf("flush_idx%0d", i));
    end

    // Reset mid-init with taken updates hammering idx 0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h0; upd_taken = 1'b1;
    pred_valid = 1'b1; pred_pc = 32'h0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midinit_rst_busy", {31'd0, init_busy}, 32'd1);
    rst_n = 1'b1;
    wait_init("rst_init");
    upd_valid = 1'b0; pred_valid = 1'b0;
    upd(32'h0, 1'b0);
    lookup(32'h0, 1'b1, 1'b0, "rst_no_leak");
    upd(32'h0, 1'b1);
    upd(32'h0, 1'b1);
    lookup(32'h0, 1'b1, 1'b1, "rst_after_train");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
